// File: rtl/avalon_mm_word_ram_slave.sv
// Avalon-MM slave: 32-bit word RAM with programmable wait states, byte enables
// and a sticky flag for simultaneous read/write requests.
module avalon_mm_word_ram_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        prot_err,
  output logic        busy
);
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_L    = 4'(WAIT_CYCLES);
  localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      rd_q;
  logic [31:0]      rdata_q;
  logic             perr_q;
  logic [31:0]      mem_q [DEPTH] = '{default: INIT_WORD};

  logic             start, complete, load_direct, load_cap;
  logic [IDX_W-1:0] idx_in;
  logic             unused_addr_lsb;

  assign idx_in          = avs_address[IDX_W+1:2];
  assign unused_addr_lsb = ^avs_address[1:0];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    avs_waitrequest = 1'b0;
    start           = 1'b0;
    complete        = 1'b0;
    load_direct     = 1'b0;
    load_cap        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avs_read || avs_write) begin
          avs_waitrequest = 1'b1;
          start           = 1'b1;
          cnt_d           = 4'd1;
          state_d         = ACTIVE;
          // With a single wait state the completion cycle follows immediately
          load_direct     = (WAIT_L == 4'd1) && !avs_write;
        end
      end
      ACTIVE: begin
        if (cnt_q < WAIT_L) begin
          avs_waitrequest = 1'b1;
          cnt_d           = cnt_q + 4'd1;
          load_cap        = (cnt_d == WAIT_L) && !wr_q;
        end else begin
          complete = 1'b1;
          cnt_d    = 4'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      perr_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start && avs_read && avs_write) perr_q <= 1'b1;
      if (load_direct)   rdata_q <= mem_q[idx_in];
      else if (load_cap) rdata_q <= rd_q;
    end
  end

  // Request fields are captured once; the master may wiggle them while stalled
  always_ff @(posedge clk) begin
    if (start) begin
      idx_q   <= idx_in;
      wr_q    <= avs_write;
      wdata_q <= avs_writedata;
      be_q    <= avs_byteenable;
      rd_q    <= mem_q[idx_in];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && complete && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign avs_readdata = rdata_q;
  assign prot_err     = perr_q;
  assign busy         = (state_q == ACTIVE);

endmodule

// File: tb/tb_avalon_mm_word_ram_slave.sv
// Randomized and directed bench for avalon_mm_word_ram_slave with a word-array
// reference model and a per-cycle output comparison.
module tb_avalon_mm_word_ram_slave;
  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest, prot_err, busy;

  avalon_mm_word_ram_slave #(.DEPTH(256), .WAIT_CYCLES(W), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .prot_err(prot_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl [256];
  logic        exp_wait, exp_busy, exp_perr;
  logic [31:0] exp_last;
  bit          chk_en = 1'b0;
  logic [31:0] rdv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("waitrequest", {31'b0, avs_waitrequest}, {31'b0, exp_wait});
        chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        chk("prot_err", {31'b0, prot_err}, {31'b0, exp_perr});
        chk("readdata", avs_readdata, exp_last);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    avs_read = 1'b0; avs_write = 1'b0;
    exp_wait = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      @(posedge clk); #1;
    end
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [9:0] addr,
                      input logic [31:0] data, input logic [3:0] be, input bit jitter,
                      output logic [31:0] rv);
    int idx;
    idx = int'(addr[9:2]);
    rv = 32'h0;
    for (int k = 0; k <= W; k++) begin
      avs_read = rd; avs_write = wr;
      if (k == 0 || !jitter) begin
        avs_address = addr; avs_writedata = data; avs_byteenable = be;
      end else begin
        avs_address = 10'($urandom); avs_writedata = $urandom; avs_byteenable = 4'($urandom);
      end
      exp_wait = (k < W);
      exp_busy = (k > 0);
      if (k == 1 && rd && wr) exp_perr = 1'b1;
      if (k == W && rd && !wr) exp_last = mdl[idx];
      if (k == W) begin
        @(negedge clk);
        rv = avs_readdata;
      end
      @(posedge clk); #1;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    end
    drive_idle();
  endtask

  task automatic do_reset(input bit mid_xfer);
    reset = 1'b1;
    avs_read = 1'b0; avs_write = 1'b0;
    exp_wait = mid_xfer; exp_busy = mid_xfer;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_wait = 1'b0; exp_busy = 1'b0; exp_perr = 1'b0; exp_last = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    exp_wait = 1'b0; exp_busy = 1'b0; exp_perr = 1'b0; exp_last = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Basic write then read
    xfer(1'b0, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF, 1'b0, rdv);
    xfer(1'b1, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0, rdv);
    chk("lit_deadbeef", rdv, 32'hDEADBEEF);

    // Byte enables on the output-block word
    xfer(1'b0, 1'b1, 10'h200, 32'h0, 4'hF, 1'b0, rdv);
    xfer(1'b0, 1'b1, 10'h200, 32'hAABBCCDD, 4'b0101, 1'b0, rdv);
    xfer(1'b1, 1'b0, 10'h200, 32'h0, 4'h0, 1'b0, rdv);
    chk("lit_be0101", rdv, 32'h00BB00DD);
    xfer(1'b0, 1'b1, 10'h200, 32'h11223344, 4'b0000, 1'b0, rdv);
    xfer(1'b1, 1'b0, 10'h202, 32'h0, 4'h0, 1'b0, rdv);
    chk("lit_be0000", rdv, 32'h00BB00DD);

    // Simultaneous read and write: write only, sticky error until reset
    xfer(1'b1, 1'b1, 10'h010, 32'h12345678, 4'hF, 1'b0, rdv);
    idle(3);
    xfer(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0, rdv);
    chk("lit_prot_wr", rdv, 32'h12345678);
    do_reset(1'b0);
    idle(2);

    // Reset in the second cycle of a pending write discards it
    xfer(1'b0, 1'b1, 10'h008, 32'h00000001, 4'hF, 1'b0, rdv);
    avs_write = 1'b1; avs_read = 1'b0; avs_address = 10'h008;
    avs_writedata = 32'hFFFFFFFF; avs_byteenable = 4'hF;
    exp_wait = 1'b1; exp_busy = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b1);
    idle(1);
    xfer(1'b1, 1'b0, 10'h008, 32'h0, 4'h0, 1'b0, rdv);
    chk("lit_rst_discard", rdv, 32'h00000001);

    // Streaming: preload, read input block, write output block, re-read input block
    for (int i = 0; i < 128; i++)
      xfer(1'b0, 1'b1, 10'(i*4), 32'hA5000000 ^ (i * 32'h00010203), 4'hF, 1'b0, rdv);
    for (int i = 0; i < 128; i++)
      xfer(1'b1, 1'b0, 10'(i*4), 32'h0, 4'h0, 1'b0, rdv);
    for (int i = 0; i < 128; i++)
      xfer(1'b0, 1'b1, 10'(512 + i*4), ~(32'(i) * 32'h01010101), 4'hF, 1'b0, rdv);
    for (int i = 0; i < 128; i += 8)
      xfer(1'b1, 1'b0, 10'(i*4), 32'h0, 4'h0, 1'b0, rdv);
    xfer(1'b1, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0, rdv);
    chk("lit_word1_kept", rdv, 32'hA5000000 ^ 32'h00010203);

    idle(10);

    // Random traffic with wiggled request fields while stalled
    for (int n = 0; n < 300; n++) begin
      logic        op;
      logic [9:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      op = 1'($urandom_range(0, 1));
      a  = 10'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      xfer(op, !op, a, d, be, 1'b1, rdv);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
